// File: rtl/axi_dma_mem_responder.sv
// AXI4 slave memory for the ECDSA interfacer DMA master: wide beats, INCR bursts, independent read/write channels.
// Optional macro AXI_MEM_RESP_STALL_EN adds LFSR-driven ready gating and fetch stretching.
module axi_dma_mem_responder #(
  parameter int C_MAXI_ADDR_WIDTH = 32,
  parameter int C_MAXI_DATA_WIDTH = 1024,
  parameter int MEM_DEPTH         = 64
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [C_MAXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]                   s_axi_awlen,
  input  logic [1:0]                   s_axi_awburst,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  input  logic [C_MAXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                         s_axi_wlast,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  output logic [1:0]                   s_axi_bresp,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  input  logic [C_MAXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [1:0]                   s_axi_arburst,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [C_MAXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic                         s_axi_rlast,
  output logic [1:0]                   s_axi_rresp
);
  localparam int ADDR_LSB = $clog2(C_MAXI_DATA_WIDTH / 8);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam int LOW_W    = ADDR_LSB + IDX_W;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_t;

  // Misaligned, non-INCR, or a burst running past the last word is rejected at the address phase.
  function automatic logic addr_err(input logic [LOW_W-1:0] addr, input logic [7:0] len,
                                    input logic [1:0] burst);
    logic [31:0] v_end;
    v_end = 32'(addr[ADDR_LSB +: IDX_W]) + 32'(len);
    return (addr[ADDR_LSB-1:0] != {ADDR_LSB{1'b0}}) || (burst != 2'b01) ||
           (v_end >= 32'(MEM_DEPTH));
  endfunction

  logic w_unused_addr;
  assign w_unused_addr = ^{s_axi_awaddr[C_MAXI_ADDR_WIDTH-1:LOW_W], s_axi_araddr[C_MAXI_ADDR_WIDTH-1:LOW_W]};

  logic w_stall_aw, w_stall_w, w_stall_ar, w_fetch_go;
`ifdef AXI_MEM_RESP_STALL_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;
  assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  // Free-running stall pattern; readies are registered from the next LFSR value so they track the current one.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_lfsr <= 16'hACE1;
    else          r_lfsr <= w_lfsr_nxt;
  end
  assign w_stall_aw = w_lfsr_nxt[3];
  assign w_stall_w  = w_lfsr_nxt[7];
  assign w_stall_ar = w_lfsr_nxt[11];
  assign w_fetch_go = ~r_lfsr[0];
`else
  assign w_stall_aw = 1'b1;
  assign w_stall_w  = 1'b1;
  assign w_stall_ar = 1'b1;
  assign w_fetch_go = 1'b1;
`endif

  logic [C_MAXI_DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];
  logic [C_MAXI_DATA_WIDTH-1:0] r_mem_q;
  logic                         w_mem_we, w_mem_re;

  wstate_t    r_wstate, w_wstate_nxt;
  logic [IDX_W-1:0] r_widx, w_widx_nxt;
  logic [7:0] r_wlen, w_wlen_nxt, r_wcnt, w_wcnt_nxt;
  logic       r_werr, w_werr_nxt;
  logic       r_awready, r_wready, r_bvalid;
  logic [1:0] r_bresp;

  // Write channel next state; a beat is stored only while the burst is error-free and within awlen.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_widx_nxt   = r_widx;
    w_wlen_nxt   = r_wlen;
    w_wcnt_nxt   = r_wcnt;
    w_werr_nxt   = r_werr;
    w_mem_we     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (s_axi_awvalid && r_awready) begin
          w_wstate_nxt = W_DATA;
          w_widx_nxt   = s_axi_awaddr[ADDR_LSB +: IDX_W];
          w_wlen_nxt   = s_axi_awlen;
          w_wcnt_nxt   = 8'd0;
          w_werr_nxt   = addr_err(s_axi_awaddr[LOW_W-1:0], s_axi_awlen, s_axi_awburst);
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && r_wready) begin
          w_mem_we   = !r_werr && (r_wcnt <= r_wlen);
          w_widx_nxt = r_widx + IDX_W'(1);
          w_wcnt_nxt = r_wcnt + 8'd1;
          if (s_axi_wlast != (r_wcnt == r_wlen)) w_werr_nxt = 1'b1;
          else                                   w_werr_nxt = r_werr;
          if (s_axi_wlast) w_wstate_nxt = W_RESP;
          else             w_wstate_nxt = W_DATA;
        end else begin
          w_wstate_nxt = W_DATA;
        end
      end
      W_RESP: begin
        if (s_axi_bready && r_bvalid) w_wstate_nxt = W_IDLE;
        else                          w_wstate_nxt = W_RESP;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write channel state and registered handshake outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate  <= W_IDLE;
      r_widx    <= {IDX_W{1'b0}};
      r_wlen    <= 8'd0;
      r_wcnt    <= 8'd0;
      r_werr    <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_widx    <= w_widx_nxt;
      r_wlen    <= w_wlen_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_werr    <= w_werr_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE) && w_stall_aw;
      r_wready  <= (w_wstate_nxt == W_DATA) && w_stall_w;
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      r_bresp   <= ((w_wstate_nxt == W_RESP) && w_werr_nxt) ? 2'b10 : 2'b00;
    end
  end

  rstate_t    r_rstate, w_rstate_nxt;
  logic [IDX_W-1:0] r_ridx, w_ridx_nxt;
  logic [7:0] r_rlen, w_rlen_nxt, r_rcnt, w_rcnt_nxt;
  logic       r_rerr, w_rerr_nxt;
  logic       r_arready, r_rvalid, r_rlast, r_rdata_en;
  logic [1:0] r_rresp;

  // Read channel next state: fetch one word, present it, repeat until beat arlen.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ridx_nxt   = r_ridx;
    w_rlen_nxt   = r_rlen;
    w_rcnt_nxt   = r_rcnt;
    w_rerr_nxt   = r_rerr;
    w_mem_re     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (s_axi_arvalid && r_arready) begin
          w_rstate_nxt = R_FETCH;
          w_ridx_nxt   = s_axi_araddr[ADDR_LSB +: IDX_W];
          w_rlen_nxt   = s_axi_arlen;
          w_rcnt_nxt   = 8'd0;
          w_rerr_nxt   = addr_err(s_axi_araddr[LOW_W-1:0], s_axi_arlen, s_axi_arburst);
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_FETCH: begin
        if (w_fetch_go) begin
          w_mem_re     = 1'b1;
          w_rstate_nxt = R_DATA;
        end else begin
          w_rstate_nxt = R_FETCH;
        end
      end
      R_DATA: begin
        if (s_axi_rready && r_rvalid) begin
          if (r_rcnt == r_rlen) begin
            w_rstate_nxt = R_IDLE;
          end else begin
            w_rstate_nxt = R_FETCH;
            w_ridx_nxt   = r_ridx + IDX_W'(1);
            w_rcnt_nxt   = r_rcnt + 8'd1;
          end
        end else begin
          w_rstate_nxt = R_DATA;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read channel state and registered response outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate   <= R_IDLE;
      r_ridx     <= {IDX_W{1'b0}};
      r_rlen     <= 8'd0;
      r_rcnt     <= 8'd0;
      r_rerr     <= 1'b0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rresp    <= 2'b00;
      r_rdata_en <= 1'b0;
    end else begin
      r_rstate   <= w_rstate_nxt;
      r_ridx     <= w_ridx_nxt;
      r_rlen     <= w_rlen_nxt;
      r_rcnt     <= w_rcnt_nxt;
      r_rerr     <= w_rerr_nxt;
      r_arready  <= (w_rstate_nxt == R_IDLE) && w_stall_ar;
      r_rvalid   <= (w_rstate_nxt == R_DATA);
      r_rlast    <= (w_rstate_nxt == R_DATA) && (w_rcnt_nxt == w_rlen_nxt);
      r_rresp    <= ((w_rstate_nxt == R_DATA) && w_rerr_nxt) ? 2'b10 : 2'b00;
      r_rdata_en <= (w_rstate_nxt == R_DATA) && !w_rerr_nxt;
    end
  end

  // Storage; the fetch reads before the same-edge write, so a colliding fetch sees the old word.
  always_ff @(posedge aclk) begin
    if (w_mem_we) r_mem[r_widx] <= s_axi_wdata;
    if (w_mem_re) r_mem_q <= r_mem[r_ridx];
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata_en ? r_mem_q : {C_MAXI_DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_axi_dma_mem_responder.sv
// Scoreboard bench for axi_dma_mem_responder: drivers push expected responses, monitors pop and compare.
module tb_axi_dma_mem_responder;
  localparam int AW = 32;
  localparam int DW = 1024;
  localparam int DEPTH = 64;
  localparam int TMO = 2000;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          awvalid = 1'b0, awready;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = 8'd0;
  logic [1:0]    awburst = 2'b01;
  logic          wvalid = 1'b0, wready, wlast = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          bvalid, bready = 1'b0;
  logic [1:0]    bresp;
  logic          arvalid = 1'b0, arready;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = 8'd0;
  logic [1:0]    arburst = 2'b01;
  logic          rvalid, rready = 1'b0, rlast;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  always #5 aclk = ~aclk;

  axi_dma_mem_responder dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
    .s_axi_awlen(awlen), .s_axi_awburst(awburst),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wlast(wlast),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
    .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
    .s_axi_rlast(rlast), .s_axi_rresp(rresp)
  );

  typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; } rexp_t;
  rexp_t         r_q[$];
  logic [1:0]    b_q[$];
  logic [DW-1:0] mem_m [DEPTH];
  int            checks = 0;
  int            errors = 0;
  bit            hold_r = 1'b0, hold_b = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 32'd128) % 32'd64);
  endfunction

  function automatic bit is_err(input logic [31:0] a, input int len, input logic [1:0] b);
    return (a % 32'd128 != 32'd0) || (b != 2'b01) || (word_of(a) + len >= DEPTH);
  endfunction

  // Random response backpressure, overridable for the hold tests.
  initial forever begin
    @(posedge aclk); #1;
    rready = hold_r ? 1'b0 : ($urandom_range(0, 3) != 0);
    bready = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Read monitor: scoreboard compare on handshake, stability compare while stalled.
  initial begin : r_mon
    logic pv, pl;
    logic [DW-1:0] pd;
    logic [1:0] pr;
    rexp_t e;
    pv = 1'b0; pl = 1'b0; pd = '0; pr = 2'b00;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          chk("r_stall_valid", rvalid, 1'b1);
          chk("r_stall_data", rdata, pd);
          chk("r_stall_resp", rresp, pr);
          chk("r_stall_last", rlast, pl);
        end
        if (rvalid && rready) begin
          pv = 1'b0;
          if (r_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected beat got resp=%0d want=no beat", rresp);
          end else begin
            e = r_q.pop_front();
            chk("r_data", rdata, e.data);
            chk("r_resp", rresp, e.resp);
            chk("r_last", rlast, e.last);
          end
        end else begin
          pv = rvalid; pd = rdata; pr = rresp; pl = rlast;
        end
      end
    end
  end

  // Write response monitor.
  initial begin : b_mon
    logic pv;
    logic [1:0] pr, e;
    pv = 1'b0; pr = 2'b00;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          chk("b_stall_valid", bvalid, 1'b1);
          chk("b_stall_resp", bresp, pr);
        end
        if (bvalid && bready) begin
          pv = 1'b0;
          if (b_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected response got=%0d want=none", bresp);
          end else begin
            e = b_q.pop_front();
            chk("b_resp", bresp, e);
          end
        end else begin
          pv = bvalid; pr = bresp;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_awready"}, awready, 1'b0);
    chk({tag, "_wready"}, wready, 1'b0);
    chk({tag, "_bvalid"}, bvalid, 1'b0);
    chk({tag, "_bresp"}, bresp, 2'b00);
    chk({tag, "_arready"}, arready, 1'b0);
    chk({tag, "_rvalid"}, rvalid, 1'b0);
    chk({tag, "_rlast"}, rlast, 1'b0);
    chk({tag, "_rresp"}, rresp, 2'b00);
    chk({tag, "_rdata"}, rdata, '0);
  endtask

  // abort_at >= 0 pulses reset instead of sending that beat.
  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst, input int abort_at);
    logic [DW-1:0] beats[$];
    bit err;
    int n;
    err = is_err(addr, len, burst);
    for (int i = 0; i <= len; i++) beats.push_back(rand_beat());
    if (abort_at < 0) b_q.push_back(err ? 2'b10 : 2'b00);
    @(posedge aclk); #1;
    awvalid = 1'b1; awaddr = addr; awlen = len[7:0]; awburst = burst;
    n = 0;
    do begin @(negedge aclk); n++; end while (!awready && n < TMO);
    chk("aw_handshake", awready, 1'b1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == abort_at) begin
        aresetn = 1'b0;
        #1;
        check_all_zero("abort");
        @(posedge aclk); #1;
        aresetn = 1'b1;
        return;
      end
      wvalid = 1'b1; wdata = beats[i]; wlast = (i == len);
      n = 0;
      do begin @(negedge aclk); n++; end while (!wready && n < TMO);
      chk("w_handshake", wready, 1'b1);
      @(posedge aclk); #1;
      wvalid = 1'b0; wlast = 1'b0;
      if (!err) mem_m[word_of(addr) + i] = beats[i];
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst);
    bit err;
    int n;
    rexp_t e;
    err = is_err(addr, len, burst);
    for (int i = 0; i <= len; i++) begin
      e.data = err ? '0 : mem_m[word_of(addr) + i];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (i == len);
      r_q.push_back(e);
    end
    @(posedge aclk); #1;
    arvalid = 1'b1; araddr = addr; arlen = len[7:0]; arburst = burst;
    n = 0;
    do begin @(negedge aclk); n++; end while (!arready && n < TMO);
    chk("ar_handshake", arready, 1'b1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0) && n < TMO) begin
      @(posedge aclk); n++;
    end
    checks++;
    if (r_q.size() != 0 || b_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got r=%0d b=%0d want 0", r_q.size(), b_q.size());
      r_q.delete(); b_q.delete();
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int widx, wlen, ridx, rlen, kind, idx, len;
    logic [31:0] a;
    logic [1:0] bu;

    repeat (3) @(posedge aclk);
    #1;
    check_all_zero("reset");
    @(posedge aclk); #1;
    aresetn = 1'b1;

    do_write(32'h0, 63, 2'b01, -1); wait_drain();

    do_write(32'h80, 0, 2'b01, -1); wait_drain();
    do_read(32'h80, 0, 2'b01); wait_drain();

    do_write(32'h100, 3, 2'b01, -1); wait_drain();
    do_read(32'h100, 3, 2'b01); wait_drain();

    do_write(32'h104, 0, 2'b01, -1); wait_drain();
    do_read(32'h100, 0, 2'b01); wait_drain();
    do_read(32'((DEPTH - 1) * 128), 1, 2'b01); wait_drain();

    hold_r = 1'b1;
    do_read(32'h100, 3, 2'b01);
    repeat (8) @(posedge aclk);
    #1;
    chk("hold_rvalid", rvalid, 1'b1);
    hold_r = 1'b0;
    wait_drain();
    hold_b = 1'b1;
    do_write(32'h300, 1, 2'b01, -1);
    repeat (6) @(posedge aclk);
    #1;
    chk("hold_bvalid", bvalid, 1'b1);
    hold_b = 1'b0;
    wait_drain();

    do_write(32'(20 * 128), 3, 2'b01, 2); wait_drain();
    do_read(32'(20 * 128), 3, 2'b01); wait_drain();
    do_write(32'(21 * 128), 1, 2'b01, -1); wait_drain();
    do_read(32'(20 * 128), 3, 2'b01); wait_drain();

    do_write(32'(5 * 128), 0, 2'b01, -1); wait_drain();
    fork
      do_write(32'(5 * 128), 0, 2'b01, -1);
      do_read(32'(5 * 128), 0, 2'b01);
    join
    wait_drain();
    do_read(32'(5 * 128), 0, 2'b01); wait_drain();

    for (int t = 0; t < 20; t++) begin
      wlen = $urandom_range(0, 7);
      rlen = $urandom_range(0, 7);
      if (t % 2 == 0) begin
        widx = $urandom_range(0, 24); ridx = $urandom_range(32, 56);
      end else begin
        widx = $urandom_range(32, 56); ridx = $urandom_range(0, 24);
      end
      fork
        do_write(32'(widx * 128), wlen, 2'b01, -1);
        do_read(32'(ridx * 128), rlen, 2'b01);
      join
      wait_drain();
    end

    for (int t = 0; t < 6; t++) begin
      kind = t % 3;
      idx = $urandom_range(0, 40);
      len = $urandom_range(0, 3);
      bu = 2'b01;
      a = 32'(idx * 128);
      if (kind == 0) begin
        a = a + 32'($urandom_range(1, 127));
      end else if (kind == 1) begin
        bu = 2'($urandom_range(0, 2));
        if (bu == 2'b01) bu = 2'b11;
      end else begin
        idx = $urandom_range(58, 63);
        len = 64 - idx + $urandom_range(0, 4);
        a = 32'(idx * 128);
      end
      if (t < 3) do_write(a, len, bu, -1);
      else       do_read(a, len, bu);
      wait_drain();
    end

    do_read(32'h0, 63, 2'b01); wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
